// File: rtl/endec_job_arbiter.sv
// endec_job_arbiter
// Round-robin front end that shares one convolutional encoder / Viterbi
// decoder engine between two requesters. Each granted job is latched, the
// engine is held in reset for RST_CYCLES, enabled until the done that
// matches the job's mode, and the result is returned on a valid/ready
// response channel tagged with the requester index.
// Optional build macro: ENDEC_WATCHDOG_EN adds a RUN-state watchdog that
// aborts a job after TIMEOUT_CYCLES and reports it through o_rsp_err.
module endec_job_arbiter #(
    parameter int GP_W           = 27,
    parameter int ENC_W          = 128,
    parameter int DEC_W          = 384,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [1:0]           i_req_mode,
    input  logic [1:0]           i_req_code_rate,
    input  logic [1:0]           i_req_constr_len,
    input  logic [2*GP_W-1:0]    i_req_gen_poly,
    input  logic [2*DEC_W-1:0]   i_req_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_id,
    output logic [DEC_W-1:0]     o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_endec_rst_n,
    output logic                 o_en,
    output logic                 o_code_rate,
    output logic                 o_constr_len,
    output logic                 o_mode_sel,
    output logic [GP_W-1:0]      o_gen_poly_flat,
    output logic [ENC_W-1:0]     o_encoder_data_frame,
    output logic [DEC_W-1:0]     o_decoder_data_frame,
    input  logic [DEC_W-1:0]     i_encoder_data,
    input  logic                 i_encoder_done,
    input  logic [ENC_W-1:0]     i_decoder_data,
    input  logic                 i_decoder_done
);

    localparam logic DECODE_MODE = 1'b1;
    localparam int   PCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q;
    logic               rr_q;
    logic               id_q;
    logic [PCW-1:0]     prep_cnt_q;
    logic               mode_q;
    logic               rate_q;
    logic               constr_q;
    logic [GP_W-1:0]    poly_q;
    logic [DEC_W-1:0]   frame_q;
    logic               rsp_valid_q;
    logic [DEC_W-1:0]   rsp_data_q;
    logic               endec_rst_n_q;
    logic               en_q;
`ifdef ENDEC_WATCHDOG_EN
    logic [12:0]        wdog_q;
    logic               rsp_err_q;
`endif

    logic               any_valid_d;
    logic               grant_d;
    logic               done_d;
    logic [DEC_W-1:0]   result_d;

    // Grant choice, matching-done select and result formatting
    always_comb begin
        any_valid_d = |i_req_valid;
        grant_d     = i_req_valid[rr_q] ? rr_q : ~rr_q;
        done_d      = (mode_q == DECODE_MODE) ? i_decoder_done : i_encoder_done;
        result_d    = (mode_q == DECODE_MODE)
                      ? {{(DEC_W-ENC_W){1'b0}}, i_decoder_data}
                      : i_encoder_data;
    end

    // Accept pulse must coincide with the cycle the descriptor is sampled,
    // so it is decoded from the current state rather than registered.
    assign o_req_ready = (state_q == IDLE && !rst && any_valid_d)
                         ? (2'b01 << grant_d) : 2'b00;

    // Job sequencer: grant, engine reset hold, run until done, respond
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= 1'b0;
            id_q          <= 1'b0;
            prep_cnt_q    <= '0;
            mode_q        <= 1'b0;
            rate_q        <= 1'b0;
            constr_q      <= 1'b0;
            poly_q        <= '0;
            frame_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            endec_rst_n_q <= 1'b0;
            en_q          <= 1'b0;
`ifdef ENDEC_WATCHDOG_EN
            wdog_q        <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    endec_rst_n_q <= 1'b0;
                    en_q          <= 1'b0;
                    if (any_valid_d) begin
                        id_q       <= grant_d;
                        rr_q       <= ~grant_d;
                        mode_q     <= i_req_mode[grant_d];
                        rate_q     <= i_req_code_rate[grant_d];
                        constr_q   <= i_req_constr_len[grant_d];
                        poly_q     <= grant_d ? i_req_gen_poly[GP_W +: GP_W]
                                              : i_req_gen_poly[0 +: GP_W];
                        frame_q    <= grant_d ? i_req_data[DEC_W +: DEC_W]
                                              : i_req_data[0 +: DEC_W];
                        prep_cnt_q <= '0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    if (prep_cnt_q == PCW'(RST_CYCLES - 1)) begin
                        endec_rst_n_q <= 1'b1;
                        en_q          <= 1'b1;
`ifdef ENDEC_WATCHDOG_EN
                        wdog_q        <= '0;
`endif
                        state_q       <= RUN;
                    end else begin
                        prep_cnt_q <= prep_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (done_d) begin
                        rsp_data_q  <= result_d;
                        rsp_valid_q <= 1'b1;
`ifdef ENDEC_WATCHDOG_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= RESP;
                    end
`ifdef ENDEC_WATCHDOG_EN
                    else if (wdog_q == 13'(TIMEOUT_CYCLES - 1)) begin
                        // Engine never finished: park it in reset and report
                        rsp_data_q    <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        endec_rst_n_q <= 1'b0;
                        en_q          <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        wdog_q <= wdog_q + 13'd1;
                    end
`endif
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
`ifdef ENDEC_WATCHDOG_EN
                        rsp_err_q     <= 1'b0;
`endif
                        endec_rst_n_q <= 1'b0;
                        en_q          <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ENDEC_WATCHDOG_EN
    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    assign o_rsp_valid          = rsp_valid_q;
    assign o_rsp_id             = id_q;
    assign o_rsp_data           = rsp_data_q;
    assign o_endec_rst_n        = endec_rst_n_q;
    assign o_en                 = en_q;
    assign o_mode_sel           = mode_q;
    assign o_code_rate          = rate_q;
    assign o_constr_len         = constr_q;
    assign o_gen_poly_flat      = poly_q;
    assign o_encoder_data_frame = frame_q[ENC_W-1:0];
    assign o_decoder_data_frame = frame_q;

endmodule

// File: tb/tb_endec_job_arbiter.sv
// tb_endec_job_arbiter
// Directed + randomized bench for endec_job_arbiter. A small job-level model
// (round-robin pointer, latched descriptor, expected result) predicts every
// grant, engine control level and response.
module tb_endec_job_arbiter;

    localparam int GP_W    = 27;
    localparam int ENC_W   = 128;
    localparam int DEC_W   = 384;
    localparam int RST_CYC = 2;
    localparam int TMO     = 16;

    logic               sys_clk = 1'b0;
    logic               rst;
    logic [1:0]         i_req_valid;
    logic [1:0]         o_req_ready;
    logic [1:0]         i_req_mode;
    logic [1:0]         i_req_code_rate;
    logic [1:0]         i_req_constr_len;
    logic [2*GP_W-1:0]  i_req_gen_poly;
    logic [2*DEC_W-1:0] i_req_data;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic               o_rsp_id;
    logic [DEC_W-1:0]   o_rsp_data;
    logic               o_rsp_err;
    logic               o_endec_rst_n;
    logic               o_en;
    logic               o_code_rate;
    logic               o_constr_len;
    logic               o_mode_sel;
    logic [GP_W-1:0]    o_gen_poly_flat;
    logic [ENC_W-1:0]   o_encoder_data_frame;
    logic [DEC_W-1:0]   o_decoder_data_frame;
    logic [DEC_W-1:0]   i_encoder_data;
    logic               i_encoder_done;
    logic [ENC_W-1:0]   i_decoder_data;
    logic               i_decoder_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int               rr;
    logic             exp_mode;
    logic [GP_W+2:0]  exp_cfg;
    logic [DEC_W-1:0] exp_frame;

    endec_job_arbiter #(
        .GP_W(GP_W), .ENC_W(ENC_W), .DEC_W(DEC_W),
        .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk(sys_clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_mode(i_req_mode), .i_req_code_rate(i_req_code_rate),
        .i_req_constr_len(i_req_constr_len), .i_req_gen_poly(i_req_gen_poly),
        .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_endec_rst_n(o_endec_rst_n), .o_en(o_en),
        .o_code_rate(o_code_rate), .o_constr_len(o_constr_len),
        .o_mode_sel(o_mode_sel), .o_gen_poly_flat(o_gen_poly_flat),
        .o_encoder_data_frame(o_encoder_data_frame),
        .o_decoder_data_frame(o_decoder_data_frame),
        .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
        .i_decoder_data(i_decoder_data), .i_decoder_done(i_decoder_done)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [DEC_W-1:0] rand_wide();
        logic [DEC_W-1:0] v;
        for (int i = 0; i < DEC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [DEC_W-1:0] obs,
                         input logic [DEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_cfg"}, {o_mode_sel, o_code_rate, o_constr_len, o_gen_poly_flat}, exp_cfg);
        check({tag, "_dec_frame"}, o_decoder_data_frame, exp_frame);
        check({tag, "_enc_frame"}, o_encoder_data_frame, exp_frame[ENC_W-1:0]);
    endtask

    task automatic jitter_reqs();
        i_req_valid      = 2'($urandom);
        i_req_mode       = 2'($urandom);
        i_req_code_rate  = 2'($urandom);
        i_req_constr_len = 2'($urandom);
        i_req_gen_poly   = {27'($urandom), 27'($urandom)};
        i_req_data       = {rand_wide(), rand_wide()};
    endtask

    // Drive engine result buses with fresh values; the done matching the
    // latched mode gets match_done, the other done is random noise.
    task automatic drive_engine(input logic match_done);
        logic [DEC_W-1:0] w;
        w              = rand_wide();
        i_encoder_data = rand_wide();
        i_decoder_data = w[ENC_W-1:0];
        if (exp_mode) begin
            i_decoder_done = match_done;
            i_encoder_done = 1'($urandom);
        end else begin
            i_encoder_done = match_done;
            i_decoder_done = 1'($urandom);
        end
    endtask

    // One job from the IDLE cycle to the return to IDLE.
    // lat < 0: done never arrives. abort: reset pulsed in the first RUN cycle.
    task automatic job(input logic [1:0] vld, input int lat, input int stall,
                       input bit abort);
        int k;
        logic [DEC_W-1:0] exp_rsp;
        i_req_valid = vld;
        #1;
        k = vld[rr] ? rr : 1 - rr;
        check("req_ready_grant", o_req_ready, (k == 0) ? 2'b01 : 2'b10);
        exp_mode  = i_req_mode[k];
        exp_cfg   = {i_req_mode[k], i_req_code_rate[k], i_req_constr_len[k],
                     (k == 1) ? i_req_gen_poly[GP_W +: GP_W] : i_req_gen_poly[0 +: GP_W]};
        exp_frame = (k == 1) ? i_req_data[DEC_W +: DEC_W] : i_req_data[0 +: DEC_W];
        rr = 1 - k;
        tick();
        // Engine reset hold
        for (int i = 0; i < RST_CYC; i++) begin
            jitter_reqs();
            drive_engine(1'($urandom));
            #1;
            check("prep_rst_n", o_endec_rst_n, 0);
            check("prep_en", o_en, 0);
            check("prep_rsp_valid", o_rsp_valid, 0);
            check("prep_req_ready", o_req_ready, 0);
            check_cfg("prep");
            tick();
        end
        check("run_rst_n", o_endec_rst_n, 1);
        check("run_en", o_en, 1);
        if (abort) begin
            i_req_valid = 2'b11;
            rst = 1'b1;
            #1;
            check("abort_en", o_en, 0);
            check("abort_rst_n", o_endec_rst_n, 0);
            check("abort_rsp_valid", o_rsp_valid, 0);
            check("abort_req_ready", o_req_ready, 0);
            tick();
            tick();
            rst = 1'b0;
            rr  = 0;
            i_encoder_done = 1'b0;
            i_decoder_done = 1'b0;
            return;
        end
        if (lat < 0) begin
`ifdef ENDEC_WATCHDOG_EN
            for (int j = 0; j < TMO; j++) begin
                drive_engine(1'b0);
                #1;
                check("wd_run_rsp_valid", o_rsp_valid, 0);
                tick();
            end
            check("wd_rsp_valid", o_rsp_valid, 1);
            check("wd_rsp_err", o_rsp_err, 1);
            check("wd_rsp_data", o_rsp_data, 0);
            check("wd_rsp_id", o_rsp_id, k);
            check("wd_rst_n", o_endec_rst_n, 0);
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            check("wd_rsp_drop", o_rsp_valid, 0);
`else
            for (int j = 0; j < 3 * TMO; j++) begin
                drive_engine(1'b0);
                #1;
                check("nowd_rsp_valid", o_rsp_valid, 0);
                check("nowd_en", o_en, 1);
                tick();
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            rr  = 0;
`endif
            return;
        end
        // Engine busy
        for (int j = 0; j < lat; j++) begin
            jitter_reqs();
            drive_engine(1'b0);
            #1;
            check("run_rsp_valid", o_rsp_valid, 0);
            check("run_req_ready", o_req_ready, 0);
            check("run_en_hold", o_en, 1);
            check_cfg("run");
            tick();
        end
        drive_engine(1'b1);
        exp_rsp = exp_mode ? {{(DEC_W-ENC_W){1'b0}}, i_decoder_data} : i_encoder_data;
        #1;
        check("done_cycle_rsp_valid", o_rsp_valid, 0);
        tick();
        // Response, possibly back-pressured
        jitter_reqs();
        drive_engine(1'($urandom));
        #1;
        check("rsp_valid", o_rsp_valid, 1);
        check("rsp_id", o_rsp_id, k);
        check("rsp_data", o_rsp_data, exp_rsp);
        check("rsp_err", o_rsp_err, 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            jitter_reqs();
            drive_engine(1'($urandom));
            #1;
            check("stall_rsp_valid", o_rsp_valid, 1);
            check("stall_rsp_id", o_rsp_id, k);
            check("stall_rsp_data", o_rsp_data, exp_rsp);
            check("stall_req_ready", o_req_ready, 0);
            check_cfg("stall");
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready    = 1'b0;
        i_encoder_done = 1'b0;
        i_decoder_done = 1'b0;
        check("idle_rsp_valid", o_rsp_valid, 0);
        check("idle_en", o_en, 0);
        check("idle_rst_n", o_endec_rst_n, 0);
        check_cfg("idle");
    endtask

    initial begin
        rr             = 0;
        rst            = 1'b1;
        i_rsp_ready    = 1'b0;
        i_encoder_done = 1'b0;
        i_decoder_done = 1'b0;
        i_encoder_data = '0;
        i_decoder_data = '0;
        jitter_reqs();
        i_req_valid = 2'b11;
        tick();
        tick();
        #1;
        // Reset state
        check("rst_req_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_rsp_id", o_rsp_id, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        check("rst_endec_rst_n", o_endec_rst_n, 0);
        check("rst_en", o_en, 0);
        exp_cfg   = '0;
        exp_frame = '0;
        check_cfg("rst");
        i_req_valid = 2'b00;
        rst = 1'b0;
        tick();
        check("idle_no_valid_ready", o_req_ready, 0);

        // Requester 0 encode, K=9, rate 1/3 polynomials
        i_req_mode[0]              = 1'b0;
        i_req_code_rate[0]         = 1'b1;
        i_req_constr_len[0]        = 1'b1;
        i_req_gen_poly[0 +: GP_W]  = {9'b100100111, 9'b110011011, 9'b111101101};
        i_req_data[0 +: DEC_W]     = rand_wide();
        job(2'b01, 3, 0, 1'b0);

        // Requester 1 decode of a short zero-extended frame, done on first RUN cycle
        i_req_mode[1]              = 1'b1;
        i_req_code_rate[1]         = 1'b0;
        i_req_constr_len[1]        = 1'b0;
        i_req_gen_poly[GP_W +: GP_W] = 27'($urandom);
        i_req_data[DEC_W +: DEC_W] = {{(DEC_W-16){1'b0}}, 16'b0010100001100111};
        job(2'b10, 0, 2, 1'b0);

        // Both requesters continuously valid: alternating grants
        for (int n = 0; n < 4; n++) begin
            jitter_reqs();
            job(2'b11, $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
        end

        // Long back-pressure on the response
        jitter_reqs();
        job(2'b11, 1, 10, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            jitter_reqs();
            job(2'($urandom_range(1, 3)), $urandom_range(0, 8), $urandom_range(0, 4), 1'b0);
        end

        // Reset mid-RUN after granting requester 0; pointer returns to 0
        jitter_reqs();
        job(2'b01, 0, 0, 1'b1);
        jitter_reqs();
        job(2'b11, 2, 1, 1'b0);

        // Engine that never signals done
        jitter_reqs();
        job(2'($urandom_range(1, 3)), -1, 0, 1'b0);
        jitter_reqs();
        job(2'b11, 1, 0, 1'b0);

        i_req_valid = 2'b00;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
